// File: rtl/mem_defs.sv
// Shared constants, size codes, fault codes and FSM states for the
// load/store sequencer and its request checker.
package mem_defs;

  localparam int BUS_WIDTH       = 32;
  localparam int I_MEM_SIZE      = 32;   // [0, 32): instruction memory, write-protected
  localparam int MEM_VECTOR_SIZE = 64;   // [32, 64): data memory
  localparam int MMIO_ADDR       = 128;  // single memory-mapped IO word

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALF     = 2'b01,
    WORD     = 2'b10,
    SIZE_BAD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    FC_NONE  = 3'b000,
    FC_SIZE  = 3'b001,  // illegal size code
    FC_ALIGN = 3'b010,  // half/word not naturally aligned
    FC_RANGE = 3'b011,  // beyond data memory and not the MMIO word
    FC_IMEM  = 3'b100,  // store into instruction memory
    FC_MMIO  = 3'b101   // MMIO accessed with less than a word
  } fault_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/mem_req_check.sv
// Purely combinational legality check for one load/store request.
// The first rule that fails determines the fault code.
module mem_req_check
  import mem_defs::*;
(
  input  logic                 we,
  input  logic [BUS_WIDTH-1:0] addr,
  input  size_e                size,
  output logic                 legal,
  output fault_code_e          code
);

  logic is_mmio;
  logic misaligned;
  logic out_of_range;

  assign is_mmio      = (addr == BUS_WIDTH'(MMIO_ADDR));
  assign misaligned   = ((size == HALF) && addr[0]) ||
                        ((size == WORD) && (addr[1:0] != 2'b00));
  // Plain unsigned compare: the top of the address space does not wrap.
  assign out_of_range = (addr >= BUS_WIDTH'(MEM_VECTOR_SIZE)) && !is_mmio;

  // Priority-ordered rule chain; the first failing rule wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    code = FC_NONE;
    if (size == SIZE_BAD) begin
      code = FC_SIZE;
    end else if (misaligned) begin
      code = FC_ALIGN;
    end else if (out_of_range) begin
      code = FC_RANGE;
    end else if (we && (addr < BUS_WIDTH'(I_MEM_SIZE))) begin
      code = FC_IMEM;
    end else if (is_mmio && (size != WORD)) begin
      code = FC_MMIO;
    end
    legal = (code == FC_NONE);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: accepts one request in IDLE, rejects
// illegal ones with a fault code, otherwise issues a single access to the
// data memory, waits MEM_LATENCY cycles and captures the read data.
module mem_access_ctrl
  import mem_defs::*;
#(
  parameter int MEM_LATENCY = 2  // must be at least 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [2:0]           fault_code,
  output logic [BUS_WIDTH-1:0] rsp_rdata
);

  localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  fault_code_e      code_q;
  logic             chk_legal;
  fault_code_e      chk_code;
  size_e            req_sz;

  assign req_sz = size_e'(req_size);

  // The live request is checked so the branch to ISSUE or FAULT is taken
  // on the very edge that accepts it.
  mem_req_check u_check (
    .we    (req_we),
    .addr  (req_addr),
    .size  (req_sz),
    .legal (chk_legal),
    .code  (chk_code)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d    = state_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    fault      = 1'b0;
    fault_code = FC_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = chk_legal ? S_ISSUE : S_FAULT;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        done       = 1'b1;
        fault      = 1'b1;
        fault_code = code_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, memory bundle, write pulse, latency counter and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= 2'b00;
      mem_sz_ex <= 1'b0;
      mem_wr_en <= 1'b0;
      rsp_rdata <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      code_q    <= FC_NONE;
    end else begin
      // The write enable is a single-cycle pulse: it only rises on acceptance.
      mem_wr_en <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            code_q <= chk_code;
            // Rejected requests leave the memory bundle untouched.
            if (chk_legal) begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_size  <= req_size;
              mem_sz_ex <= req_sz_ex && !req_we && (req_sz != WORD);
              mem_wr_en <= req_we;
              we_q      <= req_we;
            end
          end
        end
        S_ISSUE: cnt_q <= CNT_LOAD;
        S_WAIT: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              rsp_rdata <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases, boundary
// addresses, randomized requests against a rule-level reference model,
// a held-high request stream and a reset in the middle of a store.
module tb_mem_access_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sz_ex;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [1:0]  mem_size;
  logic        mem_sz_ex;
  logic        busy;
  logic        done;
  logic        fault;
  logic [2:0]  fault_code;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  // Reference state: what the memory bundle and response register should hold.
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rsp   = '0;
  logic [1:0]  exp_size  = '0;
  logic        exp_szx   = 1'b0;

  mem_access_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_sz_ex  (req_sz_ex),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_en  (mem_wr_en),
    .mem_size   (mem_size),
    .mem_sz_ex  (mem_sz_ex),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .rsp_rdata  (rsp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rule-level model: size in bytes, natural alignment by modulo, address map by range.
  function automatic int model_code(input bit we, input longint unsigned a, input int sz);
    longint unsigned nbytes;
    if (sz == 3) return 1;
    nbytes = longint'(1) << sz;
    if ((a % nbytes) != 0) return 2;
    if (a >= 64 && a != 128) return 3;
    if (we && a < 32) return 4;
    if (a == 128 && sz != 2) return 5;
    return 0;
  endfunction

  // One request from an IDLE cycle to its completion, with optional req
  // noise (illegal requests) driven while the access is in flight.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic sz_ex, input logic [31:0] rdata, input bit noise);
    int   code_exp;
    bit   legal;
    int   done_cyc;
    int   wr_cnt;
    int   wr_cyc;
    int   hold_err;
    logic f_seen;
    logic [2:0] fc_seen;
    logic szx_exp;

    code_exp = model_code(we, addr, int'(size));
    legal    = (code_exp == 0);
    szx_exp  = sz_ex && !we && (size != 2'b10);
    done_cyc = -1;
    wr_cnt   = 0;
    wr_cyc   = -1;
    hold_err = 0;
    f_seen   = 1'b0;
    fc_seen  = 3'b000;

    @(negedge clk);
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    req       = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sz_ex = sz_ex;
    mem_rdata = rdata;
    @(posedge clk);
    for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        wr_cnt++;
        wr_cyc = c;
      end
      if (done) begin
        done_cyc = c;
        f_seen   = fault;
        fc_seen  = fault_code;
      end else begin
        if (!busy) hold_err++;
        if (fault || fault_code != 3'b000) hold_err++;
        if (legal && (mem_addr !== addr || mem_size !== size ||
                      mem_wdata !== wdata || mem_sz_ex !== szx_exp)) hold_err++;
      end
      if (noise && !done) begin
        req       = 1'b1;
        req_size  = 2'b11;
        req_addr  = $urandom;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;

    check({tag, ".lat"}, done_cyc, legal ? 2 + LAT : 1);
    check({tag, ".fault"}, {31'd0, f_seen}, {31'd0, !legal});
    check({tag, ".code"}, {29'd0, fc_seen}, code_exp);
    check({tag, ".wr_cnt"}, wr_cnt, (legal && we) ? 1 : 0);
    if (legal && we) check({tag, ".wr_cyc"}, wr_cyc, 1);
    check({tag, ".hold"}, hold_err, 0);

    if (legal) begin
      exp_addr  = addr;
      exp_wdata = wdata;
      exp_size  = size;
      exp_szx   = szx_exp;
      if (!we) exp_rsp = rdata;
    end
    check({tag, ".addr"}, mem_addr, exp_addr);
    check({tag, ".wdata"}, mem_wdata, exp_wdata);
    check({tag, ".size_szx"}, {29'd0, mem_size, mem_sz_ex}, {29'd0, exp_size, exp_szx});
    check({tag, ".rsp"}, rsp_rdata, exp_rsp);
  endtask

  logic [31:0] edges [8] = '{32'd31, 32'd32, 32'd63, 32'd64, 32'd127, 32'd128, 32'd129, 32'hFFFF_FFFF};

  initial begin
    int          d1;
    int          d2;
    int          ndone;
    int          nwr;
    logic        gap_busy;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] a;

    rst       = 1'b1;
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = 2'b00;
    req_sz_ex = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ctrl", {23'd0, busy, done, fault, fault_code, mem_wr_en, mem_sz_ex, mem_size[0] | mem_size[1]}, 32'd0);
    check("reset.addr", mem_addr, 32'd0);
    check("reset.wdata", mem_wdata, 32'd0);
    check("reset.rsp", rsp_rdata, 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_req("ld_word40", 1'b0, 32'd40, 32'h1111_2222, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_req("st_byte33", 1'b1, 32'd33, 32'h0000_00A5, 2'b00, 1'b1, 32'h5555_AAAA, 1'b0);
    run_req("ld_half35", 1'b0, 32'd35, 32'h0, 2'b01, 1'b0, 32'h1, 1'b0);
    run_req("st_word8", 1'b1, 32'd8, 32'h77, 2'b10, 1'b0, 32'h2, 1'b0);
    run_req("ld_word64", 1'b0, 32'd64, 32'h0, 2'b10, 1'b0, 32'h3, 1'b0);
    run_req("size11_a3", 1'b0, 32'd3, 32'h0, 2'b11, 1'b0, 32'h4, 1'b0);
    run_req("mmio_st", 1'b1, 32'd128, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h5, 1'b0);
    run_req("mmio_ldb", 1'b0, 32'd128, 32'h0, 2'b00, 1'b1, 32'h6, 1'b0);
    run_req("ld_half_sx", 1'b0, 32'd62, 32'h0, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0);

    // Address map edges.
    run_req("st_b31", 1'b1, 32'd31, 32'h9, 2'b00, 1'b0, 32'h7, 1'b0);
    run_req("ld_b32", 1'b0, 32'd32, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
    run_req("st_b63", 1'b1, 32'd63, 32'h3C, 2'b00, 1'b0, 32'h8, 1'b0);
    run_req("ld_b127", 1'b0, 32'd127, 32'h0, 2'b00, 1'b0, 32'h9, 1'b0);
    run_req("ld_b_top", 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b00, 1'b0, 32'hA, 1'b0);
    run_req("ld_w_top", 1'b0, 32'hFFFF_FFFC, 32'h0, 2'b10, 1'b0, 32'hB, 1'b0);

    // req toggled during ISSUE/WAIT must not be queued (next idle check catches it).
    run_req("noise_ld48", 1'b0, 32'd48, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b1);

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 140));
        1:       a = edges[$urandom_range(0, 7)];
        default: a = $urandom;
      endcase
      run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // req held high across two legal loads.
    rd_a = $urandom;
    rd_b = $urandom;
    d1 = -1;
    d2 = -1;
    ndone = 0;
    nwr = 0;
    gap_busy = 1'b1;
    @(negedge clk);
    req       = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd44;
    req_wdata = 32'h0BAD_0BAD;
    req_size  = 2'b10;
    req_sz_ex = 1'b0;
    mem_rdata = rd_a;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_addr  = 32'd50;
        req_size  = 2'b01;
        req_sz_ex = 1'b1;
      end
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (mem_wr_en) nwr++;
      if (c == 2 + LAT + 1) gap_busy = busy;
      if (c == 2 + LAT + 2) begin
        req       = 1'b0;
        mem_rdata = rd_b;
      end
    end
    req = 1'b0;
    check("held.ndone", ndone, 2);
    check("held.d1", d1, 2 + LAT);
    check("held.d2", d2, (2 + LAT) + 1 + (2 + LAT));
    check("held.gap", {31'd0, gap_busy}, 32'd0);
    check("held.wr", nwr, 0);
    check("held.rsp", rsp_rdata, rd_b);
    check("held.bundle", {mem_addr[29:0], mem_size}, {30'd50, 2'b01});
    check("held.szx", {31'd0, mem_sz_ex}, 32'd1);

    // Reset during the WAIT phase of a store.
    @(negedge clk);
    req       = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd36;
    req_wdata = 32'h1234_5678;
    req_size  = 2'b10;
    req_sz_ex = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rstmid.issue_wr", {31'd0, mem_wr_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.ctrl", {24'd0, busy, done, fault, fault_code, mem_wr_en, mem_sz_ex}, 32'd0);
    check("rstmid.size", {30'd0, mem_size}, 32'd0);
    check("rstmid.addr", mem_addr, 32'd0);
    check("rstmid.wdata", mem_wdata, 32'd0);
    check("rstmid.rsp", rsp_rdata, 32'd0);
    ndone = 0;
    nwr = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (mem_wr_en) nwr++;
    end
    check("rstmid.no_done", ndone, 0);
    check("rstmid.no_wr", nwr, 0);
    exp_addr  = '0;
    exp_wdata = '0;
    exp_size  = '0;
    exp_szx   = 1'b0;
    exp_rsp   = '0;

    // Sequencer still works after the abandoned store.
    run_req("post_rst_ld", 1'b0, 32'd60, 32'h0, 2'b10, 1'b0, 32'h0F0F_F0F0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
